// File: rtl/tuss_spi_slave.sv
// SPI responder shadowing the ultrasonic driver's 16-bit configuration interface.
// sclk/nss/mosi are oversampled in the gclk domain; registers live at ADDR_BASE..ADDR_BASE+NREG-1.
module tuss_spi_slave #(
  parameter logic [5:0] ADDR_BASE   = 6'h10,
  parameter int         NREG        = 16,
  parameter int         PARITY_EN   = 0,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                gclk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                nss,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  output logic                cfg_wr,
  output logic [5:0]          cfg_addr,
  output logic [7:0]          cfg_data,
  output logic                frame_done,
  output logic [2:0]          frame_status,
  output logic [8*NREG-1:0]   cfg_regs
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, nss_sync, mosi_sync;
  logic                   sclk_d, nss_d;
  logic                   sclk_s, nss_s, mosi_s;
  logic                   sclk_fall, nss_rise;
  logic [15:0]            rx, tx, rx_next;
  logic [4:0]             cnt;
  logic [7:0]             regs [NREG];
  logic [7:0]             rd_data;
  logic [5:0]             rx_addr;
  logic                   cnt_err, par_err, addr_err;

  function automatic logic in_range(input logic [5:0] a);
    return ({1'b0, a} >= {1'b0, ADDR_BASE}) &&
           ({1'b0, a} <  ({1'b0, ADDR_BASE} + 7'(NREG)));
  endfunction

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign nss_s     = nss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign nss_rise  = ~nss_d & nss_s;

  // The top transmit bit is the miso pin, so miso is a flop output.
  assign miso      = tx[15];

  assign rx_next   = {rx[14:0], mosi_s};
  assign rx_addr   = rx[14:9];
  assign cnt_err   = (cnt != 5'd16);
  assign par_err   = (PARITY_EN != 0) && !(^rx);
  assign addr_err  = !in_range(rx_addr);

  // Read data for the byte that follows the status byte; address is rx_next[6:1] after 8 bits.
  always_comb begin
    rd_data = 8'h00;
    if (in_range(rx_next[6:1]))
      rd_data = regs[IW'(rx_next[6:1] - ADDR_BASE)];
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign cfg_regs[8*g +: 8] = regs[g];
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      nss_d     <= 1'b1;
    end else begin
      sclk_sync <= SYNC_STAGES'({sclk_sync, sclk});
      nss_sync  <= SYNC_STAGES'({nss_sync, nss});
      mosi_sync <= SYNC_STAGES'({mosi_sync, mosi});
      sclk_d    <= sclk_s;
      nss_d     <= nss_s;
    end
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rx           <= '0;
      tx           <= '0;
      cnt          <= '0;
      miso_oe      <= 1'b0;
      cfg_wr       <= 1'b0;
      cfg_addr     <= '0;
      cfg_data     <= '0;
      frame_done   <= 1'b0;
      frame_status <= '0;
      // NOTE: the register file is a flop array with a defined reset, not a RAM, so every entry is cleared here.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      // NOTE: pulse outputs default low every cycle and are raised only in the cycle that fires them.
      cfg_wr     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // Level test so a select that went low during DONE still starts a frame.
          if (!nss_s) begin
            state   <= SHIFT;
            cnt     <= '0;
            rx      <= '0;
            tx      <= {5'b0, frame_status, 8'h00};
            miso_oe <= 1'b1;
          end
        end
        SHIFT: begin
          if (nss_rise) begin
            state   <= DONE;
            miso_oe <= 1'b0;
            tx      <= '0;
          end else if (sclk_fall) begin
            rx <= rx_next;
            if (cnt != 5'd17) cnt <= cnt + 5'd1;
            if (cnt == 5'd7) tx <= {rd_data, 8'h00};
            else             tx <= {tx[14:0], 1'b0};
          end
        end
        DONE: begin
          state        <= IDLE;
          frame_done   <= 1'b1;
          frame_status <= {cnt_err, par_err, addr_err};
          if (!(cnt_err || par_err || addr_err) && rx[15]) begin
            regs[IW'(rx_addr - ADDR_BASE)] <= rx[7:0];
            cfg_wr   <= 1'b1;
            cfg_addr <= rx_addr;
            cfg_data <= rx[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tuss_spi_slave.sv
// Scoreboard bench for tuss_spi_slave: dut0 without parity, dut1 with parity.
// Expected frame results are queued by the stimulus and popped by a per-DUT monitor on frame_done.
module tb_tuss_spi_slave;

  localparam int HALF = 40;

  typedef struct {
    logic [2:0]  status;
    logic        wr;
    logic [5:0]  addr;
    logic [7:0]  data;
    int          ridx;
    logic [7:0]  rval;
    logic [15:0] miso;
    int          nmiso;
  } exp_t;

  logic         gclk = 1'b0;
  logic         rst, sclk, mosi;
  logic         nss      [2];
  logic         miso_w   [2];
  logic         oe       [2];
  logic         wr       [2];
  logic         fd       [2];
  logic [5:0]   ca       [2];
  logic [7:0]   cd       [2];
  logic [2:0]   fs       [2];
  logic [127:0] regs_o   [2];

  int           checks = 0;
  int           errors = 0;
  int           done_cnt [2] = '{0, 0};
  int           wr_cnt   [2] = '{0, 0};
  int           sent     [2] = '{0, 0};
  exp_t         sb       [2][$];
  logic [15:0]  got_q    [2][$];
  logic [15:0]  w_tmp;
  int           n_tmp;

  always #5 gclk = ~gclk;

  tuss_spi_slave #(.PARITY_EN(0)) dut0 (
    .gclk(gclk), .rst(rst), .sclk(sclk), .nss(nss[0]), .mosi(mosi),
    .miso(miso_w[0]), .miso_oe(oe[0]), .cfg_wr(wr[0]), .cfg_addr(ca[0]),
    .cfg_data(cd[0]), .frame_done(fd[0]), .frame_status(fs[0]), .cfg_regs(regs_o[0])
  );

  tuss_spi_slave #(.PARITY_EN(1)) dut1 (
    .gclk(gclk), .rst(rst), .sclk(sclk), .nss(nss[1]), .mosi(mosi),
    .miso(miso_w[1]), .miso_oe(oe[1]), .cfg_wr(wr[1]), .cfg_addr(ca[1]),
    .cfg_data(cd[1]), .frame_done(fd[1]), .frame_status(fs[1]), .cfg_regs(regs_o[1])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic expect_frame(input int d, input logic [2:0] st, input logic w,
                              input logic [5:0] a, input logic [7:0] dt, input int ridx,
                              input logic [7:0] rv, input logic [15:0] m, input int nm);
    exp_t e;
    e.status = st; e.wr = w; e.addr = a; e.data = dt;
    e.ridx = ridx; e.rval = rv; e.miso = m; e.nmiso = nm;
    sb[d].push_back(e);
    sent[d]++;
  endtask

  // Master drives mosi on sclk rise and samples miso just before each rise.
  task automatic clock_bits(input int d, input logic [31:0] bits, input int nbits,
                            output logic [15:0] w, output int n);
    w = '0;
    n = 0;
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) begin
        w = {w[14:0], miso_w[d]};
        n++;
      end
      sclk = 1'b1;
      mosi = bits[nbits-1-i];
      #HALF;
      sclk = 1'b0;
      #HALF;
    end
  endtask

  task automatic send_frame(input int d, input logic [31:0] bits, input int nbits, input int gap);
    logic [15:0] w;
    int          n;
    nss[d] = 1'b0;
    #100;
    clock_bits(d, bits, nbits, w, n);
    #HALF;
    nss[d] = 1'b1;
    if (n > 0) w = w << (16 - n);
    got_q[d].push_back(w);
    #gap;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_miso"},         {31'b0, miso_w[0]}, 32'd0);
    check({tag, "_miso_oe"},      {31'b0, oe[0]},     32'd0);
    check({tag, "_cfg_wr"},       {31'b0, wr[0]},     32'd0);
    check({tag, "_cfg_addr"},     {26'b0, ca[0]},     32'd0);
    check({tag, "_cfg_data"},     {24'b0, cd[0]},     32'd0);
    check({tag, "_frame_done"},   {31'b0, fd[0]},     32'd0);
    check({tag, "_frame_status"}, {29'b0, fs[0]},     32'd0);
    check({tag, "_regs_zero"},    {31'b0, |regs_o[0]}, 32'd0);
  endtask

  task automatic monitor(input int d);
    exp_t        e;
    logic [15:0] m, mask;
    forever begin
      @(negedge gclk);
      if (wr[d]) wr_cnt[d]++;
      if (fd[d]) begin
        done_cnt[d]++;
        if (sb[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d_unexpected_frame status=%b", d, fs[d]);
        end else begin
          e = sb[d].pop_front();
          m = (got_q[d].size() != 0) ? got_q[d].pop_front() : 16'hxxxx;
          check($sformatf("dut%0d_frame%0d_status", d, done_cnt[d]), {29'b0, fs[d]}, {29'b0, e.status});
          check($sformatf("dut%0d_frame%0d_cfg_wr", d, done_cnt[d]), {31'b0, wr[d]}, {31'b0, e.wr});
          if (e.wr) begin
            check($sformatf("dut%0d_frame%0d_cfg_addr", d, done_cnt[d]), {26'b0, ca[d]}, {26'b0, e.addr});
            check($sformatf("dut%0d_frame%0d_cfg_data", d, done_cnt[d]), {24'b0, cd[d]}, {24'b0, e.data});
          end
          if (e.ridx >= 0)
            check($sformatf("dut%0d_frame%0d_reg%0d", d, done_cnt[d], e.ridx),
                  {24'b0, regs_o[d][8*e.ridx +: 8]}, {24'b0, e.rval});
          if (e.nmiso > 0) begin
            mask = 16'hFFFF << (16 - e.nmiso);
            check($sformatf("dut%0d_frame%0d_miso", d, done_cnt[d]), {16'b0, m & mask}, {16'b0, e.miso & mask});
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    nss[0] = 1'b1;
    nss[1] = 1'b1;
    repeat (3) @(negedge gclk);
    check_reset("por");
    rst = 1'b0;
    repeat (5) @(negedge gclk);

    // dut, status, wr, addr, data, reg idx, reg val, miso word, miso bits
    expect_frame(0, 3'b000, 1, 6'h10, 8'h25,  0, 8'h25, 16'h0000, 16);
    send_frame(0, 32'hA025, 16, 200);
    expect_frame(0, 3'b000, 1, 6'h1A, 8'h0A, 10, 8'h0A, 16'h0000, 16);
    send_frame(0, 32'hB50A, 16, 200);
    expect_frame(0, 3'b000, 0, 6'h00, 8'h00, 10, 8'h0A, 16'h000A, 16);
    send_frame(0, 32'h3400, 16, 200);
    expect_frame(0, 3'b001, 0, 6'h00, 8'h00,  0, 8'h25, 16'h0000, 16);
    send_frame(0, 32'h8A77, 16, 200);
    expect_frame(0, 3'b000, 0, 6'h00, 8'h00,  0, 8'h25, 16'h0125, 16);
    send_frame(0, 32'h2000, 16, 200);
    expect_frame(0, 3'b101, 0, 6'h00, 8'h00,  0, 8'h25, 16'h0025, 10);
    send_frame(0, 32'h0283, 10, 200);
    expect_frame(0, 3'b101, 0, 6'h00, 8'h00,  0, 8'h25, 16'h0525, 16);
    send_frame(0, 32'h14067, 17, 200);
    expect_frame(0, 3'b101, 0, 6'h00, 8'h00,  0, 8'h25, 16'h0000, 0);
    send_frame(0, 32'h0, 0, 200);

    // Reset in the middle of a write frame after the first byte.
    nss[0] = 1'b0;
    #100;
    clock_bits(0, 32'hA1, 8, w_tmp, n_tmp);
    check("mid_frame_miso_oe", {31'b0, oe[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    @(negedge gclk);
    nss[0] = 1'b1;
    repeat (3) @(negedge gclk);
    rst = 1'b0;
    repeat (5) @(negedge gclk);

    expect_frame(0, 3'b000, 1, 6'h10, 8'h25,  0, 8'h25, 16'h0000, 16);
    send_frame(0, 32'hA025, 16, 200);
    expect_frame(0, 3'b000, 1, 6'h1F, 8'hC3, 15, 8'hC3, 16'h0000, 16);
    send_frame(0, 32'hBFC3, 16, 20);
    expect_frame(0, 3'b000, 0, 6'h00, 8'h00, 15, 8'hC3, 16'h00C3, 16);
    send_frame(0, 32'h3E00, 16, 200);

    expect_frame(1, 3'b010, 0, 6'h00, 8'h00,  0, 8'h00, 16'h0000, 16);
    send_frame(1, 32'hA125, 16, 200);
    expect_frame(1, 3'b000, 1, 6'h10, 8'h25,  0, 8'h25, 16'h0200, 16);
    send_frame(1, 32'hA025, 16, 200);

    for (int i = 0; i < 1000 && (sb[0].size() != 0 || sb[1].size() != 0); i++)
      @(negedge gclk);
    repeat (5) @(negedge gclk);
    check("scoreboard_drained", sb[0].size() + sb[1].size(), 32'd0);
    check("dut0_frame_count", done_cnt[0], sent[0]);
    check("dut1_frame_count", done_cnt[1], sent[1]);
    check("dut0_write_count", wr_cnt[0], 32'd4);
    check("dut1_write_count", wr_cnt[1], 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
